gowin_pll_reconfig: RTL and testbench
=====================================

# gowin_pll_reconfig

Dynamic reconfiguration controller for the Gowin PLLA modulation/dynamic-reconfig port (MDOPC/MDWDI/MDRDO). On request it places the PLL in reset and streams one of several parametrised register profiles (addr/data pairs from an external synchronous table) into the PLL. It optionally read-back-verifies each write, then releases reset and waits for lock with a timeout. It sits beside the PLL wrapper at the clocking top level; the PLL MDCLK pin is tied to the same clkin.

## Interface
- PROFILES, 4, number of selectable register profiles
- ENTRIES, 8, table slots per profile
- VERIFY, 1, 1 = read back and compare every written register
- RST_CYCLES, 16, extra cycles pll_reset is held after last write (≥1)
- LOCK_TIMEOUT, 65535, max cycles waiting for pll_lock after reset release
- PW = $clog2(PROFILES), TW = $clog2(PROFILES*ENTRIES) (localparams)

- clkin  in  1  controller clock, also drives PLL MDCLK
- reset  in  1  synchronous, active-high
- req  in  1  start reconfiguration; sampled only in IDLE
- req_profile  in  PW  profile index, sampled with req
- busy  out  1  high from the cycle after accepted req until DONE/ERR exit
- done  out  1  one-cycle pulse on successful lock
- err  out  1  sticky error flag, cleared by next accepted req
- err_code  out  2  0 none, 1 verify mismatch, 2 lock timeout, 3 bad profile
- cur_profile  out  PW  last successfully applied profile
- tbl_addr  out  TW  table address = profile*ENTRIES + index
- tbl_data  in  17  {last, reg_addr[7:0], reg_data[7:0]}, valid 1 cycle after tbl_addr
- pll_reset  out  1  PLL RESET
- pll_lock  in  1  PLL LOCK (already synchronous to clkin)
- mdopc  out  2  00 NOP, 01 write, 10 read, 11 load address
- mdainc  out  1  held 0
- mdwdi  out  8  address/data to PLL
- mdrdo  in  8  PLL read data

## Operation
- States: IDLE, FETCH, TWAIT, ADDR, WRITE, GAP, READ, RWAIT1, RWAIT2, CHECK, HOLD, LOCKWAIT, DONE, ERR.
- IDLE: req & req_profile < PROFILES → FETCH, index=0, pll_reset=1, err cleared. req_profile ≥ PROFILES → ERR with code 3, pll_reset untouched, no md activity.
- FETCH: drive tbl_addr. TWAIT: capture tbl_data.
- ADDR: mdopc=11, mdwdi=reg_addr. WRITE: mdopc=01, mdwdi=reg_data. GAP: mdopc=00.
- VERIFY=1: READ (mdopc=10, mdwdi=0) → RWAIT1 → RWAIT2 → CHECK compares mdrdo to reg_data. Mismatch → ERR code 1, pll_reset released. Match → next entry.
- Next entry: if last=1 or index==ENTRIES-1 → HOLD, else index+1 → FETCH. An entry is never skipped; index wrap is impossible.
- HOLD: count RST_CYCLES with pll_reset=1, then pll_reset=0 → LOCKWAIT.
- LOCKWAIT: pll_lock=1 → DONE. Counter reaching LOCK_TIMEOUT → ERR code 2.
- DONE: done=1 for one cycle, cur_profile←profile → IDLE.
- ERR: → IDLE, err stays 1 with code held.
- mdopc=00 and mdwdi=0 in every state not listed above.

## Timing
- Reset values: busy 0, done 0, err 0, err_code 0, cur_profile 0 (default defparam config), tbl_addr 0, pll_reset 0, mdopc 00, mdainc 0, mdwdi 0.
- All outputs registered; req at edge N → busy=1 and pll_reset=1 at N+1.
- Per-entry cost: 5 cycles (VERIFY=0) or 9 cycles (VERIFY=1). mdrdo is sampled exactly 3 cycles after the READ opcode cycle.
- Total to done, for E entries with lock at L cycles after release: 1 + E*per_entry + RST_CYCLES + L + 1.
- req while busy: ignored, not queued. req in the DONE/ERR cycle: ignored.
- reset mid-operation: all outputs to reset values next edge, pll_reset drops. A partially written PLL is left as-is; cur_profile reads 0.
- pll_lock dropping after DONE: not monitored.

## Test plan
- Profile 1, 3 entries, VERIFY=1, model echoes writes, lock 20 cycles after release → mdopc sequence 11,01,00,10 per entry with correct addr/data; done pulse at cycle 1+27+16+20+1; cur_profile=1.
- Profile 2, entry 1 read model returns data^0x01 → err=1, err_code=1, pll_reset=0, no HOLD, cur_profile unchanged, busy falls.
- pll_lock held 0, LOCK_TIMEOUT=100 → err_code=2 exactly 100 cycles after pll_reset falls.
- req_profile=5 with PROFILES=4 → err_code=3 next cycle, pll_reset never asserted, mdopc stays 00.
- Second req during WRITE, then reset asserted in HOLD → second req ignored; next cycle all outputs at reset values, pll_reset=0, FSM in IDLE.
- VERIFY=0, full 8-entry profile with last=0 → 8 writes at 5 cycles each, stops at index 7, tbl_addr never exceeds profile*8+7.

Source files
------------

// File: rtl/gowin_pll_reconfig.sv
// rtl/gowin_pll_reconfig.sv - Gowin PLLA dynamic reconfiguration controller
// Streams a table profile into the PLL MD port under reset, optionally reads back, then waits for lock.
module gowin_pll_reconfig #(
  parameter int PROFILES     = 4,
  parameter int ENTRIES      = 8,
  parameter int VERIFY       = 1,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  localparam int PW = $clog2(PROFILES),
  localparam int TW = $clog2(PROFILES*ENTRIES)
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          req,
  input  logic [PW-1:0] req_profile,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [PW-1:0] cur_profile,
  output logic [TW-1:0] tbl_addr,
  input  logic [16:0]   tbl_data,
  output logic          pll_reset,
  input  logic          pll_lock,
  output logic [1:0]    mdopc,
  output logic          mdainc,
  output logic [7:0]    mdwdi,
  input  logic [7:0]    mdrdo
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CMAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [1:0] MD_NOP   = 2'b00;
  localparam logic [1:0] MD_WRITE = 2'b01;
  localparam logic [1:0] MD_READ  = 2'b10;
  localparam logic [1:0] MD_ADDR  = 2'b11;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_VERIFY  = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_PROFILE = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_TWAIT, S_ADDR, S_WRITE, S_GAP, S_READ, S_RWAIT1,
    S_RWAIT2, S_CHECK, S_HOLD, S_LOCKWAIT, S_DONE, S_ERR
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   prof, prof_d;
  logic [IW-1:0]   idx, idx_d;
  logic            ent_last, ent_last_d;
  logic [7:0]      ent_data, ent_data_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d, done_d, err_d, pll_reset_d;
  logic [1:0]      err_code_d, mdopc_d;
  logic [PW-1:0]   cur_profile_d;
  logic [TW-1:0]   tbl_addr_d;
  logic [7:0]      mdwdi_d;
  logic            advance, last_entry, bad_profile;

  function automatic logic [TW-1:0] slot(input logic [PW-1:0] p, input logic [IW-1:0] i);
    return TW'(int'(p) * ENTRIES + int'(i));
  endfunction

  assign mdainc      = 1'b0;
  assign bad_profile = (int'(req_profile) >= PROFILES);
  assign last_entry  = ent_last || (idx == IW'(ENTRIES - 1));

  always_comb begin
    state_d       = state;
    prof_d        = prof;
    idx_d         = idx;
    ent_last_d    = ent_last;
    ent_data_d    = ent_data;
    cnt_d         = cnt;
    err_d         = err;
    err_code_d    = err_code;
    cur_profile_d = cur_profile;
    tbl_addr_d    = tbl_addr;
    pll_reset_d   = pll_reset;
    done_d        = 1'b0;
    mdopc_d       = MD_NOP;
    mdwdi_d       = 8'h00;
    advance       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (bad_profile) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = E_PROFILE;
          end else begin
            state_d     = S_FETCH;
            prof_d      = req_profile;
            idx_d       = '0;
            tbl_addr_d  = slot(req_profile, '0);
            pll_reset_d = 1'b1;
            err_d       = 1'b0;
            err_code_d  = E_NONE;
          end
        end
      end
      S_FETCH: state_d = S_TWAIT;
      S_TWAIT: begin
        // Table data is valid now; launch the address load straight from it.
        ent_last_d = tbl_data[16];
        ent_data_d = tbl_data[7:0];
        mdopc_d    = MD_ADDR;
        mdwdi_d    = tbl_data[15:8];
        state_d    = S_ADDR;
      end
      S_ADDR: begin
        mdopc_d = MD_WRITE;
        mdwdi_d = ent_data;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_GAP;
      S_GAP: begin
        if (VERIFY != 0) begin
          mdopc_d = MD_READ;
          state_d = S_READ;
        end else begin
          advance = 1'b1;
        end
      end
      S_READ:   state_d = S_RWAIT1;
      S_RWAIT1: state_d = S_RWAIT2;
      S_RWAIT2: state_d = S_CHECK;
      S_CHECK: begin
        if (mdrdo != ent_data) begin
          state_d     = S_ERR;
          err_d       = 1'b1;
          err_code_d  = E_VERIFY;
          pll_reset_d = 1'b0;
        end else begin
          advance = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == CW'(RST_CYCLES - 1)) begin
          state_d     = S_LOCKWAIT;
          pll_reset_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_LOCKWAIT: begin
        if (pll_lock) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          cur_profile_d = prof;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = E_TIMEOUT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (last_entry) begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end else begin
        idx_d      = idx + 1'b1;
        tbl_addr_d = slot(prof, idx + 1'b1);
        state_d    = S_FETCH;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= S_IDLE;
      prof        <= '0;
      idx         <= '0;
      ent_last    <= 1'b0;
      ent_data    <= 8'h00;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= E_NONE;
      cur_profile <= '0;
      tbl_addr    <= '0;
      pll_reset   <= 1'b0;
      mdopc       <= MD_NOP;
      mdwdi       <= 8'h00;
    end else begin
      state       <= state_d;
      prof        <= prof_d;
      idx         <= idx_d;
      ent_last    <= ent_last_d;
      ent_data    <= ent_data_d;
      cnt         <= cnt_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
      err_code    <= err_code_d;
      cur_profile <= cur_profile_d;
      tbl_addr    <= tbl_addr_d;
      pll_reset   <= pll_reset_d;
      mdopc       <= mdopc_d;
      mdwdi       <= mdwdi_d;
    end
  end

endmodule

// File: tb/tb_gowin_pll_reconfig.sv
// tb/tb_gowin_pll_reconfig.sv - directed bench for gowin_pll_reconfig
// Instance A: verify on, 4 profiles; instance B: verify off, 5 profiles.
module tb_gowin_pll_reconfig;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req_a, busy_a, done_a, err_a, prst_a, lock_a, mdainc_a;
  logic [1:0]  prof_a, code_a, cur_a, mdopc_a;
  logic [4:0]  taddr_a;
  logic [16:0] tdata_a;
  logic [7:0]  mdwdi_a;
  logic [7:0]  mdrdo_a = 8'h00;

  logic        req_b, busy_b, done_b, err_b, prst_b, lock_b, mdainc_b;
  logic [2:0]  prof_b, cur_b;
  logic [1:0]  code_b, mdopc_b;
  logic [5:0]  taddr_b;
  logic [16:0] tdata_b;
  logic [7:0]  mdwdi_b;
  wire  [7:0]  mdrdo_b = 8'h00;

  gowin_pll_reconfig #(
    .PROFILES(4), .ENTRIES(8), .VERIFY(1), .RST_CYCLES(16), .LOCK_TIMEOUT(100)
  ) dut_a (
    .clkin(clk), .reset(reset), .req(req_a), .req_profile(prof_a),
    .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a),
    .cur_profile(cur_a), .tbl_addr(taddr_a), .tbl_data(tdata_a),
    .pll_reset(prst_a), .pll_lock(lock_a), .mdopc(mdopc_a), .mdainc(mdainc_a),
    .mdwdi(mdwdi_a), .mdrdo(mdrdo_a)
  );

  gowin_pll_reconfig #(
    .PROFILES(5), .ENTRIES(8), .VERIFY(0), .RST_CYCLES(16), .LOCK_TIMEOUT(100)
  ) dut_b (
    .clkin(clk), .reset(reset), .req(req_b), .req_profile(prof_b),
    .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b),
    .cur_profile(cur_b), .tbl_addr(taddr_b), .tbl_data(tdata_b),
    .pll_reset(prst_b), .pll_lock(lock_b), .mdopc(mdopc_b), .mdainc(mdainc_b),
    .mdwdi(mdwdi_b), .mdrdo(mdrdo_b)
  );

  // Profile table: profile 0 ends at entry 0, profiles 1/2 at entry 2, others run all 8.
  function automatic logic [7:0] exp_addr(input int p, input int i);
    return 8'(p * 16 + i);
  endfunction

  function automatic logic [7:0] exp_data(input int p, input int i);
    return 8'(90 ^ (p * 16 + i * 3));
  endfunction

  function automatic logic [16:0] tbl_entry(input int p, input int i);
    logic last;
    last = (p == 0 && i == 0) || ((p == 1 || p == 2) && i == 2);
    return {last, exp_addr(p, i), exp_data(p, i)};
  endfunction

  always @(posedge clk) begin
    tdata_a <= tbl_entry(int'(taddr_a) / 8, int'(taddr_a) % 8);
    tdata_b <= tbl_entry(int'(taddr_b) / 8, int'(taddr_b) % 8);
  end

  // PLL register file for A; a read of flip_addr returns data with bit 0 inverted.
  logic [7:0] pregs_a [256];
  logic [7:0] pa_addr = 8'h00;
  logic [8:0] flip_addr;
  logic [9:0] log_a [$];

  always @(posedge clk) begin
    case (mdopc_a)
      2'b11: pa_addr <= mdwdi_a;
      2'b01: pregs_a[pa_addr] <= mdwdi_a;
      2'b10: mdrdo_a <= pregs_a[pa_addr] ^ {7'd0, ({1'b0, pa_addr} == flip_addr)};
      default: ;
    endcase
    if (busy_a) log_a.push_back({mdopc_a, mdwdi_a});
  end

  int         wr_cnt_b = 0;
  int         rd_cnt_b = 0;
  logic [7:0] wr_last_b = 8'h00;
  logic [5:0] max_taddr_b = 6'd0;

  always @(posedge clk) begin
    if (busy_b) begin
      if (mdopc_b == 2'b01) begin
        wr_cnt_b  <= wr_cnt_b + 1;
        wr_last_b <= mdwdi_b;
      end
      if (mdopc_b == 2'b10) rd_cnt_b <= rd_cnt_b + 1;
      if (taddr_b > max_taddr_b) max_taddr_b <= taddr_b;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string pfx);
    chk({pfx, "_busy"}, busy_a, 0);
    chk({pfx, "_done"}, done_a, 0);
    chk({pfx, "_err"}, err_a, 0);
    chk({pfx, "_code"}, code_a, 0);
    chk({pfx, "_cur"}, cur_a, 0);
    chk({pfx, "_taddr"}, taddr_a, 0);
    chk({pfx, "_prst"}, prst_a, 0);
    chk({pfx, "_mdopc"}, mdopc_a, 0);
    chk({pfx, "_mdainc"}, mdainc_a, 0);
    chk({pfx, "_mdwdi"}, mdwdi_a, 0);
  endtask

  initial begin
    int base;
    int wr0;
    reset = 1'b1;
    req_a = 1'b0; prof_a = 2'd0; lock_a = 1'b0;
    req_b = 1'b0; prof_b = 3'd0; lock_b = 1'b0;
    flip_addr = 9'h100;
    step(3);
    chk_reset_a("rst");
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_prst", prst_b, 0);
    reset = 1'b0;
    step(2);

    // Profile 1, three verified entries, lock after 20 cycles of LOCKWAIT.
    base = log_a.size();
    req_a = 1'b1; prof_a = 2'd1;
    step(1);
    req_a = 1'b0;
    chk("t1_busy", busy_a, 1);
    chk("t1_prst", prst_a, 1);
    chk("t1_taddr", taddr_a, 8);
    step(42);
    chk("t1_hold_last", prst_a, 1);
    step(1);
    chk("t1_release", prst_a, 0);
    chk("t1_busy_lw", busy_a, 1);
    step(19);
    chk("t1_done_early", done_a, 0);
    lock_a = 1'b1;
    step(1);
    chk("t1_done", done_a, 1);
    chk("t1_cur", cur_a, 1);
    step(1);
    chk("t1_done_pulse", done_a, 0);
    chk("t1_busy_end", busy_a, 0);
    lock_a = 1'b0;
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("t1_addr%0d", e), log_a[base + 9*e + 2], {2'b11, exp_addr(1, e)});
      chk($sformatf("t1_write%0d", e), log_a[base + 9*e + 3], {2'b01, exp_data(1, e)});
      chk($sformatf("t1_gap%0d", e), log_a[base + 9*e + 4], 0);
      chk($sformatf("t1_read%0d", e), log_a[base + 9*e + 5], {2'b10, 8'h00});
    end

    // Profile 2, entry 1 reads back corrupted.
    flip_addr = {1'b0, exp_addr(2, 1)};
    req_a = 1'b1; prof_a = 2'd2;
    step(1);
    req_a = 1'b0;
    chk("t2_busy", busy_a, 1);
    step(17);
    chk("t2_err_early", err_a, 0);
    chk("t2_prst_check", prst_a, 1);
    step(1);
    chk("t2_err", err_a, 1);
    chk("t2_code", code_a, 1);
    chk("t2_prst", prst_a, 0);
    step(1);
    chk("t2_busy_end", busy_a, 0);
    chk("t2_err_sticky", err_a, 1);
    chk("t2_code_held", code_a, 1);
    chk("t2_cur", cur_a, 1);
    flip_addr = 9'h100;

    // Profile 0, lock never arrives: timeout 100 cycles after release.
    req_a = 1'b1; prof_a = 2'd0;
    step(1);
    req_a = 1'b0;
    chk("t3_err_clr", err_a, 0);
    chk("t3_code_clr", code_a, 0);
    step(24);
    chk("t3_hold_last", prst_a, 1);
    step(1);
    chk("t3_release", prst_a, 0);
    step(99);
    chk("t3_err_early", err_a, 0);
    chk("t3_busy_lw", busy_a, 1);
    step(1);
    chk("t3_err", err_a, 1);
    chk("t3_code", code_a, 2);
    step(1);
    chk("t3_busy_end", busy_a, 0);
    chk("t3_cur", cur_a, 1);

    // Out-of-range profile on B.
    req_b = 1'b1; prof_b = 3'd5;
    step(1);
    req_b = 1'b0;
    chk("t4_err", err_b, 1);
    chk("t4_code", code_b, 3);
    chk("t4_prst", prst_b, 0);
    chk("t4_mdopc", mdopc_b, 0);
    step(1);
    chk("t4_err_sticky", err_b, 1);
    chk("t4_busy_end", busy_b, 0);
    chk("t4_prst2", prst_b, 0);
    chk("t4_mdopc2", mdopc_b, 0);

    // Second req during WRITE is dropped; reset in HOLD aborts everything.
    req_a = 1'b1; prof_a = 2'd1;
    step(1);
    req_a = 1'b0;
    step(3);
    chk("t5_write", mdopc_a, 1);
    req_a = 1'b1; prof_a = 2'd2;
    step(1);
    req_a = 1'b0;
    chk("t5_gap", mdopc_a, 0);
    step(5);
    chk("t5_taddr", taddr_a, 9);
    step(21);
    chk("t5_hold", prst_a, 1);
    reset = 1'b1;
    step(1);
    chk_reset_a("t5");
    reset = 1'b0;
    step(3);
    chk("t5_idle_busy", busy_a, 0);
    chk("t5_idle_mdopc", mdopc_a, 0);
    chk("t5_idle_prst", prst_a, 0);

    // B: full 8-entry profile without read-back.
    wr0 = wr_cnt_b;
    req_b = 1'b1; prof_b = 3'd3;
    step(1);
    req_b = 1'b0;
    chk("t6_busy", busy_b, 1);
    chk("t6_taddr", taddr_b, 24);
    step(55);
    chk("t6_hold_last", prst_b, 1);
    step(1);
    chk("t6_release", prst_b, 0);
    lock_b = 1'b1;
    step(1);
    chk("t6_done", done_b, 1);
    chk("t6_cur", cur_b, 3);
    step(1);
    lock_b = 1'b0;
    chk("t6_busy_end", busy_b, 0);
    chk("t6_writes", wr_cnt_b - wr0, 8);
    chk("t6_reads", rd_cnt_b, 0);
    chk("t6_max_taddr", max_taddr_b, 31);
    chk("t6_last_data", wr_last_b, exp_data(3, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
